// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD constants for the serial adder
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if: operand/result handshake bus for bcd_serial_adder
// ports: in_valid/in_ready + a, b, ci, sub (operands); out_valid/out_ready + s, co, err (result)
// err exists only when BCD_INVALID_DETECT_EN is defined
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] a;
    logic [4*DIGITS-1:0] b;
    logic                ci;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] s;
    logic                co;
`ifdef BCD_INVALID_DETECT_EN
    logic                err;
`endif
    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co
`ifdef BCD_INVALID_DETECT_EN
        , err
`endif
    );
    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co
`ifdef BCD_INVALID_DETECT_EN
        , err
`endif
    );
endinterface

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one BCD digit of A + B (or A + nines(B)) + cin with decimal correction
// ports: a_d, b_d digits, cin carry-in, sub selects nines complement of b_d; s_d digit, cout carry-out
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s_d,
    output logic       cout
);
    logic [3:0] bc;
    logic [4:0] t;
    always_comb begin
        bc   = sub ? BCD_MAX - b_d : b_d;
        t    = {1'b0, a_d} + {1'b0, bc} + {4'b0, cin};
        cout = t > 5'd9;
        s_d  = cout ? t[3:0] + 4'd6 : t[3:0];
    end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit BCD adder/subtractor, one digit per clock, LSD first
// ports: clk, rst (async active-high), bus (bcd_serial_adder_if.slave)
// define BCD_INVALID_DETECT_EN to flag operand digits above 9 on bus.err
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_serial_adder_if.slave     bus
);
    localparam int W  = DIGIT_W * DIGITS;
    localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
    logic          sub_q, sub_d, carry_q, carry_d, co_q, co_d;
    logic [3:0]    dig_s;
    logic          dig_c;
`ifdef BCD_INVALID_DETECT_EN
    logic          err_q, err_d;
`endif
    // operands shift right each digit so the adder always sees bit [3:0]; results shift in from the top
    bcd_digit_adder u_digit (
        .a_d  (a_q[3:0]),
        .b_d  (b_q[3:0]),
        .cin  (carry_q),
        .sub  (sub_q),
        .s_d  (dig_s),
        .cout (dig_c)
    );
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        co_d    = co_q;
`ifdef BCD_INVALID_DETECT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = RUN;
                k_d     = '0;
                a_d     = bus.a;
                b_d     = bus.b;
                s_d     = '0;
                sub_d   = bus.sub;
                carry_d = bus.ci;
                co_d    = 1'b0;
`ifdef BCD_INVALID_DETECT_EN
                err_d   = 1'b0;
`endif
            end
            RUN: begin
                a_d     = a_q >> DIGIT_W;
                b_d     = b_q >> DIGIT_W;
                s_d     = W'({dig_s, s_q} >> DIGIT_W);
                carry_d = dig_c;
                k_d     = k_q + KW'(1);
`ifdef BCD_INVALID_DETECT_EN
                err_d   = err_q | (a_q[3:0] > BCD_MAX) | (b_q[3:0] > BCD_MAX);
`endif
                if (k_q == KW'(DIGITS - 1)) begin
                    state_d = DONE;
                    co_d    = dig_c;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
`ifdef BCD_INVALID_DETECT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            co_q    <= co_d;
`ifdef BCD_INVALID_DETECT_EN
            err_q   <= err_d;
`endif
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.s         = s_q;
    assign bus.co        = co_q;
`ifdef BCD_INVALID_DETECT_EN
    assign bus.err       = err_q;
`endif
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: vector table, corner sequences and random decimal model for bcd_serial_adder
module tb_bcd_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;

    bcd_serial_adder_if #(.DIGITS(4)) bus ();
    bcd_serial_adder #(.DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic civ, input logic subv,
                         output logic [15:0] sv, output logic cov, output logic errv, output int lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a = av;
        bus.b = bv;
        bus.ci = civ;
        bus.sub = subv;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = ~av;
        bus.b = ~bv;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) chk("out_valid_timeout", 32'(lat), 32'd4);
        sv = bus.s;
        cov = bus.co;
`ifdef BCD_INVALID_DETECT_EN
        errv = bus.err;
`else
        errv = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sv;
        logic        cov, errv;
        int          lat;
        tbl[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0};
        tbl[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
        tbl[3] = '{16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1};
        tbl[4] = '{16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.ci = 1'b0;
        bus.sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_co", 32'(bus.co), 32'd0);
`ifdef BCD_INVALID_DETECT_EN
        chk("rst_err", 32'(bus.err), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, sv, cov, errv, lat);
            chk($sformatf("vec%0d_s", i), 32'(sv), 32'(tbl[i].s));
            chk($sformatf("vec%0d_co", i), 32'(cov), 32'(tbl[i].co));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_err", i), 32'(errv), 32'd0);
        end

        // result held while consumer stalls, new operands ignored
        @(negedge clk);
        bus.a = 16'h1234;
        bus.b = 16'h5678;
        bus.ci = 1'b0;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_reach_done", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
            chk("hold_s", 32'(bus.s), 32'h6912);
            chk("hold_co", 32'(bus.co), 32'd0);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);

        // reset mid-run discards the operation asynchronously
        bus.a = 16'h1234;
        bus.b = 16'h5678;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_s", 32'(bus.s), 32'd0);
        chk("midrst_co", 32'(bus.co), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0009, 16'h0009, 1'b1, 1'b0, sv, cov, errv, lat);
        chk("post_rst_s", 32'(sv), 32'h0019);
        chk("post_rst_co", 32'(cov), 32'd0);

`ifdef BCD_INVALID_DETECT_EN
        do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, sv, cov, errv, lat);
        chk("inv_err", 32'(errv), 32'd1);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, sv, cov, errv, lat);
        chk("inv_clear_err", 32'(errv), 32'd0);
        chk("inv_clear_s", 32'(sv), 32'h0002);
`endif

        // random decimal operands against integer arithmetic
        for (int i = 0; i < 40; i++) begin
            int av, bv, tot;
            logic civ, subv;
            av = int'($urandom_range(0, 9999));
            bv = int'($urandom_range(0, 9999));
            civ = 1'($urandom);
            subv = 1'($urandom);
            tot = av + (subv ? 9999 - bv : bv) + int'(civ);
            do_op(to_bcd(av), to_bcd(bv), civ, subv, sv, cov, errv, lat);
            chk($sformatf("rnd%0d_s", i), 32'(sv), 32'(to_bcd(tot % 10000)));
            chk($sformatf("rnd%0d_co", i), 32'(cov), 32'(tot >= 10000));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, with a valid/ready handshake on both sides. It succeeds the single-digit combinational decimal adder and is the arithmetic core for the team's multi-digit calculator and counter-display datapaths. Operands and result are packed BCD, 4 bits per digit.

## Interface
- DIGITS, 4, number of BCD digits per operand, ≥1
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  4*DIGITS  packed BCD operand A; digit 0 in [3:0]
- b  in  4*DIGITS  packed BCD operand B
- ci  in  1  carry-in to digit 0
- sub  in  1  0: A+B+ci; 1: A+nines(B)+ci
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  4*DIGITS  packed BCD result
- co  out  1  carry-out of top digit; in sub mode 1 = no borrow
- err  out  1  invalid-digit flag (only with BCD_INVALID_DETECT_EN)

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, ci, sub; clear digit index k=0, carry=ci; → RUN.
- RUN: each cycle digit k: b'=sub ? 9−b_k : b_k; t=a_k+b'+carry (5-bit, max 19); if t>9 then s_k=(t+6)[3:0], carry=1, else s_k=t[3:0], carry=0. k increments; after k=DIGITS−1 → DONE, co=final carry.
- DONE: out_valid=1; s, co (and err) held stable until out_valid&&out_ready, then → IDLE.
- Plain subtraction A−B: caller drives sub=1, ci=1. co=0 means negative; s is then the ten's complement.
- in_valid outside IDLE is ignored; latched operands are not affected by input changes after accept.
- Digits >9 on input: no special handling; same correction rule applies (deterministic result).
- Reset asserted at any time, including mid-RUN: state → IDLE immediately, operation discarded.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, s=0, co=0, err=0, k=0.
- Accept edge = cycle 0. Digits processed on edges 1..DIGITS; out_valid high after edge DIGITS.
- If out_ready already high in DONE: IDLE after edge DIGITS+1; next accept earliest at edge DIGITS+2. Throughput: one operation per DIGITS+2 cycles.
- out_ready low: DONE held indefinitely, outputs stable.
- in_ready and out_valid are decoded from state register only (no combinational path from in_valid/out_ready).
- s is cleared to 0 on accept; intermediate digits visible in s during RUN are not valid.

## Configuration
- BCD_INVALID_DETECT_EN defined: err port present; err cleared on accept, set if any latched digit of a or b exceeds 9 (checked on raw b, before complement); valid with out_valid, held in DONE. s/co computed identically.
- Not defined: err port and checking logic absent; behaviour otherwise identical.

## Structure
- Shared package bcd_pkg: state enum (IDLE, RUN, DONE), DIGIT_W=4 constant, BCD_MAX=9 constant.
- One sub-module: bcd_digit_adder — combinational single digit: a_d, b_d, cin, sub → s_d, cout (complement + decimal correction). Top holds FSM, index counter, operand/result registers.

## Test plan
- DIGITS=4, a=1234, b=5678, ci=0, sub=0 → s=6912, co=0; out_valid exactly 4 cycles after accept edge.
- a=9999, b=0001, ci=0 → s=0000, co=1; a=0000, b=0000, ci=1 → s=0001, co=0.
- sub=1, ci=1: a=0500, b=0123 → s=0377, co=1; a=0123, b=0500 → s=9623, co=0.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b → s, co stable, in_ready=0, no new accept; release → IDLE next edge, in_ready=1.
- Assert rst after 2 RUN digits → all outputs to reset values asynchronously; then a=0009, b=0009, ci=1 → s=0019, co=0.
- With BCD_INVALID_DETECT_EN: a=00A0 (hex digit), b=0000 → err=1 with out_valid; next op 0001+0001 → err=0, s=0002.
